// File: rtl/miriscv_lsu_pkg.sv
// Shared LSU-side types: memory arbiter FSM states and requester source IDs.
package miriscv_lsu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD_I,
        ARB_HOLD_D
    } arb_state_e;

    localparam logic ARB_SRC_INSTR = 1'b0;
    localparam logic ARB_SRC_DATA  = 1'b1;

endpackage

// File: rtl/miriscv_arb_id_fifo.sv
// In-order FIFO of source IDs for accepted-but-unanswered bus transactions.
module miriscv_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory bus port between fetch and LSU: fixed data priority, request lock until
// grant, in-order response routing via an outstanding-ID FIFO.
module miriscv_mem_arbiter
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              protocol_err_o
);

    arb_state_e state_q, state_d;
    logic       err_q;
    logic       req_pending, sel_data, bus_gnt;
    logic       fifo_full, fifo_empty, fifo_head, fifo_pop;

    // A held state pins the source regardless of what the other requester does.
    always_comb begin
        unique case (state_q)
            ARB_HOLD_I: begin
                req_pending = 1'b1;
                sel_data    = ARB_SRC_INSTR;
            end
            ARB_HOLD_D: begin
                req_pending = 1'b1;
                sel_data    = ARB_SRC_DATA;
            end
            default: begin
                req_pending = data_req_i | instr_req_i;
                sel_data    = data_req_i ? ARB_SRC_DATA : ARB_SRC_INSTR;
            end
        endcase
    end

    assign mem_req_o = req_pending & ~fifo_full & ~rst_i;
    assign bus_gnt   = mem_req_o & mem_gnt_i;
    assign fifo_pop  = mem_rvalid_i & ~fifo_empty;

    always_comb begin
        state_d = state_q;
        if (mem_req_o) begin
            if (mem_gnt_i) begin
                state_d = ARB_IDLE;
            end else begin
                state_d = (sel_data == ARB_SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | (mem_rvalid_i & fifo_empty);
        end
    end

    // Fetch always reads a full word, so it drives all byte enables.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel_data == ARB_SRC_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o   = '1;
                mem_addr_o = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o    = bus_gnt & (sel_data == ARB_SRC_INSTR);
    assign data_gnt_o     = bus_gnt & (sel_data == ARB_SRC_DATA);
    assign instr_rvalid_o = ~rst_i & fifo_pop & (fifo_head == ARB_SRC_INSTR);
    assign data_rvalid_o  = ~rst_i & fifo_pop & (fifo_head == ARB_SRC_DATA);
    assign instr_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign data_rdata_o   = rst_i ? '0 : mem_rdata_i;
    assign protocol_err_o = err_q & ~rst_i;

    miriscv_arb_id_fifo #(
        .Depth (MAX_OUTSTANDING),
        .Width (1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus_gnt),
        .wdata_i (sel_data),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed vector table for the documented scenarios, then randomized traffic against a
// queue-based reference model.
module tb_miriscv_mem_arbiter;

    localparam int unsigned MaxOut = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq, dwe, mgnt, mrvalid;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dbe;
    logic        igrant, irv, dgnt, drv, mreq, mwe, perr;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic [3:0]  mbe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    miriscv_mem_arbiter #(
        .XLEN            (32),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (ireq),
        .instr_addr_i   (iaddr),
        .instr_gnt_o    (igrant),
        .instr_rvalid_o (irv),
        .instr_rdata_o  (irdata),
        .data_req_i     (dreq),
        .data_we_i      (dwe),
        .data_be_i      (dbe),
        .data_addr_i    (daddr),
        .data_wdata_i   (dwdata),
        .data_gnt_o     (dgnt),
        .data_rvalid_o  (drv),
        .data_rdata_o   (drdata),
        .mem_req_o      (mreq),
        .mem_we_o       (mwe),
        .mem_be_o       (mbe),
        .mem_addr_o     (maddr),
        .mem_wdata_o    (mwdata),
        .mem_gnt_i      (mgnt),
        .mem_rvalid_i   (mrvalid),
        .mem_rdata_i    (mrdata),
        .protocol_err_o (perr)
    );

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, ireq, dreq, dwe, mgnt, mrv;
        logic [31:0] iaddr, daddr, dwdata, mrdata;
        logic [3:0]  dbe;
        logic        e_req, e_we, e_ig, e_dg, e_irv, e_drv, e_err;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rst_v, logic ireq_v, logic [31:0] iaddr_v,
        logic dreq_v, logic dwe_v, logic [3:0] dbe_v, logic [31:0] daddr_v, logic [31:0] dwd_v,
        logic mgnt_v, logic mrv_v, logic [31:0] mrd_v,
        logic e_req_v, logic [31:0] e_addr_v, logic e_we_v, logic [3:0] e_be_v,
        logic [31:0] e_wd_v, logic e_ig_v, logic e_dg_v, logic e_irv_v, logic e_drv_v,
        logic [31:0] e_rd_v, logic e_err_v);
        vec_t v;
        v.rst = rst_v; v.ireq = ireq_v; v.iaddr = iaddr_v;
        v.dreq = dreq_v; v.dwe = dwe_v; v.dbe = dbe_v; v.daddr = daddr_v; v.dwdata = dwd_v;
        v.mgnt = mgnt_v; v.mrv = mrv_v; v.mrdata = mrd_v;
        v.e_req = e_req_v; v.e_addr = e_addr_v; v.e_we = e_we_v; v.e_be = e_be_v;
        v.e_wdata = e_wd_v; v.e_ig = e_ig_v; v.e_dg = e_dg_v; v.e_irv = e_irv_v;
        v.e_drv = e_drv_v; v.e_rdata = e_rd_v; v.e_err = e_err_v;
        return v;
    endfunction

    // Apply inputs just after a rising edge, sample at the falling edge.
    task automatic apply_inputs(input vec_t v);
        rst = v.rst; ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; dwe = v.dwe;
        dbe = v.dbe; daddr = v.daddr; dwdata = v.dwdata; mgnt = v.mgnt;
        mrvalid = v.mrv; mrdata = v.mrdata;
    endtask

    task automatic check_outputs(input int cyc, input vec_t v);
        chk("mem_req", cyc, 32'(mreq), 32'(v.e_req));
        chk("mem_addr", cyc, maddr, v.e_addr);
        chk("mem_we", cyc, 32'(mwe), 32'(v.e_we));
        chk("mem_be", cyc, 32'(mbe), 32'(v.e_be));
        chk("mem_wdata", cyc, mwdata, v.e_wdata);
        chk("instr_gnt", cyc, 32'(igrant), 32'(v.e_ig));
        chk("data_gnt", cyc, 32'(dgnt), 32'(v.e_dg));
        chk("instr_rvalid", cyc, 32'(irv), 32'(v.e_irv));
        chk("data_rvalid", cyc, 32'(drv), 32'(v.e_drv));
        chk("instr_rdata", cyc, irdata, v.e_rdata);
        chk("data_rdata", cyc, drdata, v.e_rdata);
        chk("protocol_err", cyc, 32'(perr), 32'(v.e_err));
    endtask

    // Reference model state: outstanding source queue (1 = data), locked source, sticky error.
    bit   src_q[$];
    int   lock_src;  // 0 none, 1 fetch, 2 data
    bit   err_m;
    bit          i_pend, d_pend, d_we_m;
    logic [31:0] i_addr_m, d_addr_m, d_wd_m;
    logic [3:0]  d_be_m;

    initial begin
        vec_t v;
        // rst ireq iaddr  dreq we be daddr wdata  gnt rv rdata | req addr we be wd ig dg irv drv rd err
        vecs.push_back(mk(1,1,32'h100, 1,1,4'hF,32'h2000,32'hDEAD, 1,1,32'h55,
                          0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0, 1,0,0,
                          1,32'h100,0,4'hF,0, 1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,32'h13,
                          0,0,0,0,0, 0,0,1,0,32'h13,0));
        vecs.push_back(mk(0,1,32'h100, 1,1,4'hF,32'h2000,32'hDEAD, 1,0,0,
                          1,32'h2000,1,4'hF,32'hDEAD, 0,1,0,0,0,0));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0, 1,0,0,
                          1,32'h100,0,4'hF,0, 1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,32'hAAAA,
                          0,0,0,0,0, 0,0,0,1,32'hAAAA,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,32'hBBBB,
                          0,0,0,0,0, 0,0,1,0,32'hBBBB,0));
        // hold lock on fetch while data rises
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0, 0,0,0,
                          1,32'h100,0,4'hF,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h100, 1,1,4'h3,32'h3000,32'h1234_5678, 0,0,0,
                          1,32'h100,0,4'hF,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h100, 1,1,4'h3,32'h3000,32'h1234_5678, 0,0,0,
                          1,32'h100,0,4'hF,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h100, 1,1,4'h3,32'h3000,32'h1234_5678, 1,0,0,
                          1,32'h100,0,4'hF,0, 1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,4'h3,32'h3000,32'h1234_5678, 1,0,0,
                          1,32'h3000,1,4'h3,32'h1234_5678, 0,1,0,0,0,0));
        // full: blocked, no same-cycle bypass, granted the cycle after the pop
        vecs.push_back(mk(0,1,32'h104, 0,0,0,0,0, 1,0,0,
                          0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h104, 0,0,0,0,0, 1,1,32'h11,
                          0,0,0,0,0, 0,0,1,0,32'h11,0));
        vecs.push_back(mk(0,1,32'h104, 0,0,0,0,0, 1,1,32'h22,
                          1,32'h104,0,4'hF,0, 1,0,0,1,32'h22,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,32'h33,
                          0,0,0,0,0, 0,0,1,0,32'h33,0));
        // spurious response
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,32'h44,
                          0,0,0,0,0, 0,0,0,0,32'h44,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,
                          0,0,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(0,1,32'h108, 0,0,0,0,0, 1,0,0,
                          1,32'h108,0,4'hF,0, 1,0,0,0,0,1));
        // reset with one outstanding, then a late response
        vecs.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0,
                          0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,32'h55,
                          0,0,0,0,0, 0,0,0,0,32'h55,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,
                          0,0,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(0,1,32'h10C, 0,0,0,0,0, 1,0,0,
                          1,32'h10C,0,4'hF,0, 1,0,0,0,0,1));

        apply_inputs(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_inputs(vecs[i]);
            @(negedge clk);
            check_outputs(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // Reset for the random phase.
        v = mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
        apply_inputs(v);
        @(posedge clk);
        #1;
        src_q.delete();
        lock_src = 0;
        err_m = 0;
        i_pend = 0;
        d_pend = 0;

        for (int c = 0; c < 3000; c++) begin
            bit full;
            int win;
            bit rv_has;
            if (!i_pend) begin
                i_addr_m = $urandom & 32'hFFFF_FFFC;
                i_pend = ($urandom_range(0, 2) == 0);
            end
            if (!d_pend) begin
                d_addr_m = $urandom;
                d_wd_m = $urandom;
                d_be_m = 4'($urandom);
                d_we_m = 1'($urandom);
                d_pend = ($urandom_range(0, 2) == 0);
            end
            v.rst = 0;
            v.ireq = i_pend; v.iaddr = i_addr_m;
            v.dreq = d_pend; v.daddr = d_addr_m; v.dwdata = d_wd_m;
            v.dbe = d_be_m; v.dwe = d_we_m;
            v.mgnt = ($urandom_range(0, 3) != 0);
            v.mrv = (src_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                       : ($urandom_range(0, 199) == 0);
            v.mrdata = $urandom;

            full = (src_q.size() >= MaxOut);
            win = (lock_src != 0) ? lock_src : (d_pend ? 2 : (i_pend ? 1 : 0));
            v.e_req = !full && (win != 0);
            v.e_addr = !v.e_req ? 32'h0 : (win == 2 ? d_addr_m : i_addr_m);
            v.e_we = v.e_req && win == 2 && d_we_m;
            v.e_be = !v.e_req ? 4'h0 : (win == 2 ? d_be_m : 4'hF);
            v.e_wdata = (v.e_req && win == 2) ? d_wd_m : 32'h0;
            v.e_ig = v.e_req && v.mgnt && win == 1;
            v.e_dg = v.e_req && v.mgnt && win == 2;
            rv_has = v.mrv && src_q.size() > 0;
            v.e_irv = rv_has && src_q[0] == 1'b0;
            v.e_drv = rv_has && src_q[0] == 1'b1;
            v.e_rdata = v.mrdata;
            v.e_err = err_m;

            apply_inputs(v);
            @(negedge clk);
            check_outputs(1000 + c, v);

            if (v.mrv) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                else err_m = 1;
            end
            if (v.e_req) begin
                if (v.mgnt) begin
                    src_q.push_back(win == 2);
                    lock_src = 0;
                end else begin
                    lock_src = win;
                end
            end
            if (v.e_ig) i_pend = 0;
            if (v.e_dg) d_pend = 0;
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
